// File: rtl/periph_pkg.sv
// Shared types and widths for the peripheral TX packetizer.
package periph_pkg;

  localparam int NUM_PERIPH   = 8;
  localparam int PERIPH_ID_W  = 3;
  localparam int TX_PAYLOAD_W = 29;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    ADVANCE
  } pkt_state_t;

endpackage

// File: rtl/periph_tx_packetizer.sv
// Drains the granted peripheral FWFT FIFO into the FT601 TX stream as {id, payload} words,
// yielding after MAX_BURST words or when drained. Optional counters: PACKETIZER_STATS_EN.
module periph_tx_packetizer #(
  parameter int NUM_PERIPH = periph_pkg::NUM_PERIPH,
  parameter int PAYLOAD_W  = periph_pkg::TX_PAYLOAD_W,
  parameter int MAX_BURST  = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [periph_pkg::PERIPH_ID_W-1:0]      grant,
  input  logic [NUM_PERIPH-1:0]                   rx_fifo_empty,
  input  logic [NUM_PERIPH*PAYLOAD_W-1:0]         rx_fifo_data,
  output logic [NUM_PERIPH-1:0]                   rx_fifo_rd_en,
  output logic                                    read_periph_data,
  output logic [periph_pkg::PERIPH_ID_W+PAYLOAD_W-1:0] tx_data,
`ifdef PACKETIZER_STATS_EN
  output logic [31:0]                             stat_words,
  output logic [15:0]                             stat_bursts,
`endif
  output logic                                    tx_valid,
  input  logic                                    tx_ready
);

  import periph_pkg::*;

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_BURST);

  pkt_state_t             state;
  pkt_state_t             state_next;
  logic [PERIPH_ID_W-1:0] burst_id;
  logic [CNT_W-1:0]       count;
  logic                   head_empty;
  logic [PAYLOAD_W-1:0]   head_data;
  logic                   xfer;

  // Everything inside a burst keys off the id latched at entry, not the live grant.
  assign head_empty = rx_fifo_empty[burst_id];
  assign head_data  = rx_fifo_data[burst_id*PAYLOAD_W +: PAYLOAD_W];
  assign xfer       = (state == BURST) && !head_empty && tx_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!rx_fifo_empty[grant]) begin
          state_next = BURST;
        end else if (!(&rx_fifo_empty)) begin
          state_next = ADVANCE;
        end
      end
      BURST: begin
        if (head_empty || (xfer && (count == LAST_CNT))) begin
          state_next = ADVANCE;
        end
      end
      ADVANCE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_valid         = 1'b0;
    tx_data          = '0;
    rx_fifo_rd_en    = '0;
    read_periph_data = 1'b0;
    case (state)
      BURST: begin
        tx_valid = !head_empty;
        tx_data  = {burst_id, head_data};
        if (xfer) begin
          rx_fifo_rd_en[burst_id] = 1'b1;
        end
      end
      ADVANCE: read_periph_data = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      burst_id <= '0;
      count    <= '0;
    end else if ((state == IDLE) && (state_next == BURST)) begin
      burst_id <= grant;
      count    <= '0;
    end else if (xfer && (count != FULL_CNT)) begin
      count <= count + CNT_W'(1);
    end
  end

`ifdef PACKETIZER_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_words  <= '0;
      stat_bursts <= '0;
    end else begin
      if (xfer && (stat_words != '1)) begin
        stat_words <= stat_words + 32'd1;
      end
      if ((state == BURST) && (state_next == ADVANCE) && (stat_bursts != '1)) begin
        stat_bursts <= stat_bursts + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_periph_tx_packetizer.sv
// Directed bench for periph_tx_packetizer: modelled FWFT FIFOs, table-driven bursts and stall/reset sequences.
module tb_periph_tx_packetizer;

  logic        clk;
  logic        rst;
  logic [2:0]  grant;
  logic [7:0]  rx_fifo_empty;
  logic [231:0] rx_fifo_data;
  logic [7:0]  rx_fifo_rd_en;
  logic        read_periph_data;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
`ifdef PACKETIZER_STATS_EN
  logic [31:0] stat_words;
  logic [15:0] stat_bursts;
`endif

  periph_tx_packetizer #(
    .NUM_PERIPH(8),
    .PAYLOAD_W (29),
    .MAX_BURST (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .grant           (grant),
    .rx_fifo_empty   (rx_fifo_empty),
    .rx_fifo_data    (rx_fifo_data),
    .rx_fifo_rd_en   (rx_fifo_rd_en),
    .read_periph_data(read_periph_data),
    .tx_data         (tx_data),
`ifdef PACKETIZER_STATS_EN
    .stat_words      (stat_words),
    .stat_bursts     (stat_bursts),
`endif
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [28:0] mem [8][64];
  int unsigned head [8];
  int unsigned tail [8];

  typedef struct {
    int    g;
    int    f;
    int    n;
    int    xfers;
    int    pulse_c;
    string tag;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [28:0] payload(input int f, input int k);
    return 29'(f * 1048576 + k * 257 + 5);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < 8; i++) begin
      rx_fifo_empty[i] = (head[i] == tail[i]);
      rx_fifo_data[i*29 +: 29] = (head[i] == tail[i]) ? 29'd0 : mem[i][head[i]];
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < 8; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    refresh();
  endtask

  task automatic load(input int f, input int start, input int n);
    for (int k = 0; k < n; k++) begin
      mem[f][tail[f]] = payload(f, start + k);
      tail[f]++;
    end
    refresh();
  endtask

  // Pops follow the rd_en the DUT presented just before the edge.
  task automatic tick();
    logic [7:0] popped;
    popped = rx_fifo_rd_en;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      if (popped[i] && (head[i] != tail[i])) head[i]++;
    end
    refresh();
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, {31'd0, tx_valid}, 32'd0);
    check({tag, "_rden"}, {24'd0, rx_fifo_rd_en}, 32'd0);
    check({tag, "_pulse"}, {31'd0, read_periph_data}, 32'd0);
  endtask

  // Cycle 0 is the IDLE cycle in which the FIFOs were loaded; ready held high.
  task automatic run_burst(input int g, input int f, input int start, input int xfers,
                           input int pulse_c, input string tag);
    bit in_xfer;
    grant    = 3'(g);
    tx_ready = 1'b1;
    #1;
    for (int c = 0; c <= pulse_c; c++) begin
      in_xfer = (c >= 1) && (c <= xfers);
      check($sformatf("%s_valid_c%0d", tag, c), {31'd0, tx_valid}, {31'd0, in_xfer});
      if (in_xfer)
        check($sformatf("%s_data_c%0d", tag, c), tx_data, {3'(g), payload(f, start + c - 1)});
      check($sformatf("%s_rden_c%0d", tag, c), {24'd0, rx_fifo_rd_en},
            in_xfer ? (32'd1 << f) : 32'd0);
      check($sformatf("%s_pulse_c%0d", tag, c), {31'd0, read_periph_data},
            {31'd0, (c == pulse_c)});
      if (c == pulse_c) clear_all();
      tick();
    end
    check_quiet({tag, "_after"});
  endtask

  int          st_ready [5];
  int          st_idx   [5];

  initial begin
    vecs[0] = '{g: 2, f: 2, n: 3,  xfers: 3,  pulse_c: 5,  tag: "case1_g2"};
    vecs[1] = '{g: 5, f: 5, n: 40, xfers: 16, pulse_c: 17, tag: "case2_max"};
    vecs[2] = '{g: 0, f: 0, n: 1,  xfers: 1,  pulse_c: 3,  tag: "one_word"};
    vecs[3] = '{g: 7, f: 7, n: 16, xfers: 16, pulse_c: 17, tag: "exact_max"};
    vecs[4] = '{g: 3, f: 3, n: 17, xfers: 16, pulse_c: 17, tag: "max_plus1"};
    vecs[5] = '{g: 0, f: 6, n: 4,  xfers: 0,  pulse_c: 1,  tag: "case4_adv"};
    vecs[6] = '{g: 4, f: 4, n: 2,  xfers: 2,  pulse_c: 4,  tag: "g4_two"};

    rst = 1'b0;
    grant = 3'd0;
    tx_ready = 1'b0;
    rx_fifo_empty = '1;
    rx_fifo_data = '0;
    clear_all();
    #1;
    check_quiet("reset_t0");
    tick();
    tick();
    check_quiet("reset_held");
    rst = 1'b1;
    #1;

    for (int v = 0; v < 7; v++) begin
      clear_all();
      load(vecs[v].f, 0, vecs[v].n);
      run_burst(vecs[v].g, vecs[v].f, 0, vecs[v].xfers, vecs[v].pulse_c, vecs[v].tag);
    end

    // Stalls with a mid-burst grant change: the burst stays on FIFO1 and keeps order.
    st_ready = '{1, 0, 0, 1, 1};
    st_idx   = '{0, 1, 1, 1, 2};
    clear_all();
    load(1, 0, 3);
    load(4, 0, 2);
    grant = 3'd1;
    tx_ready = 1'b1;
    #1;
    check("stall_c0_valid", {31'd0, tx_valid}, 32'd0);
    tick();
    for (int c = 0; c < 5; c++) begin
      tx_ready = st_ready[c][0];
      if (c == 1) grant = 3'd4;
      #1;
      check($sformatf("stall_valid_c%0d", c + 1), {31'd0, tx_valid}, 32'd1);
      check($sformatf("stall_data_c%0d", c + 1), tx_data, {3'd1, payload(1, st_idx[c])});
      check($sformatf("stall_rden_c%0d", c + 1), {24'd0, rx_fifo_rd_en},
            (st_ready[c] != 0) ? 32'h02 : 32'h00);
      tick();
    end
    check("stall_drained_valid", {31'd0, tx_valid}, 32'd0);
    check("stall_drained_pulse", {31'd0, read_periph_data}, 32'd0);
    tick();
    check("stall_pulse", {31'd0, read_periph_data}, 32'd1);
    check("stall_pulse_rden", {24'd0, rx_fifo_rd_en}, 32'd0);
    clear_all();
    tick();
    check_quiet("stall_after");

    // All FIFOs empty: nothing ever moves.
    clear_all();
    for (int c = 0; c < 20; c++) begin
      grant = 3'(c % 8);
      tx_ready = c[0];
      #1;
      check_quiet($sformatf("all_empty_c%0d", c));
      tick();
    end

    // Asynchronous reset in the middle of a burst, then a clean restart.
    clear_all();
    load(2, 0, 6);
    grant = 3'd2;
    tx_ready = 1'b1;
    #1;
    check("rst_c0_valid", {31'd0, tx_valid}, 32'd0);
    tick();
    check("rst_c1_data", tx_data, {3'd2, payload(2, 0)});
    check("rst_c1_rden", {24'd0, rx_fifo_rd_en}, 32'h04);
    tick();
    check("rst_c2_data", tx_data, {3'd2, payload(2, 1)});
    check("rst_c2_rden", {24'd0, rx_fifo_rd_en}, 32'h04);
    #2;
    rst = 1'b0;
    #1;
    check_quiet("rst_async");
    tick();
    check_quiet("rst_edge");
    check("rst_no_pop_head", head[2], 32'd1);
    rst = 1'b1;
    run_burst(2, 2, 1, 5, 7, "rst_resume");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
